// File: rtl/regfile_hilo.sv
// rtl/regfile_hilo.sv - 32x32 GPR file with two combinational read ports and a HI/LO pair
// Write-back bypass on reads is selectable; r0 is hardwired to zero.
module regfile_hilo #(
  parameter bit FWD_EN  = 1'b1,
  parameter bit HILO_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        whilo,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] r_gpr [32];
  logic        w_wr_en;

  // Entry 0 is never written, so it stays at its reset value of zero.
  assign w_wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_gpr[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      r_gpr[waddr] <= wdata;
    end
  end

  // Enable is tested before the address so an unknown address on an idle port stays out.
  always_comb begin
    rdata1 = 32'd0;
    if (!rst || !re1 || raddr1 == 5'd0) begin
      rdata1 = 32'd0;
    end else if (FWD_EN && we && raddr1 == waddr) begin
      rdata1 = wdata;
    end else begin
      rdata1 = r_gpr[raddr1];
    end
  end

  always_comb begin
    rdata2 = 32'd0;
    if (!rst || !re2 || raddr2 == 5'd0) begin
      rdata2 = 32'd0;
    end else if (FWD_EN && we && raddr2 == waddr) begin
      rdata2 = wdata;
    end else begin
      rdata2 = r_gpr[raddr2];
    end
  end

  generate
    if (HILO_EN) begin : g_hilo
      logic [31:0] r_hi;
      logic [31:0] r_lo;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_hi <= 32'd0;
          r_lo <= 32'd0;
        end else if (whilo) begin
          r_hi <= hi_i;
          r_lo <= lo_i;
        end
      end

      always_comb begin
        hi_o = 32'd0;
        lo_o = 32'd0;
        if (!rst) begin
          hi_o = 32'd0;
          lo_o = 32'd0;
        end else if (FWD_EN && whilo) begin
          hi_o = hi_i;
          lo_o = lo_i;
        end else begin
          hi_o = r_hi;
          lo_o = r_lo;
        end
      end
    end else begin : g_no_hilo
      assign hi_o = 32'd0;
      assign lo_o = 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_hilo.sv
// tb/tb_regfile_hilo.sv - self-checking bench for regfile_hilo, bypass and non-bypass builds
// Both builds share stimulus; expectations come from an array model of the register file.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic        whilo;
  logic [31:0] hi_i;
  logic [31:0] lo_i;

  logic [31:0] f_rdata1, f_rdata2, f_hi_o, f_lo_o;
  logic [31:0] n_rdata1, n_rdata2, n_hi_o, n_lo_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  regfile_hilo #(.FWD_EN(1'b1), .HILO_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(f_rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(f_rdata2),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i), .hi_o(f_hi_o), .lo_o(f_lo_o)
  );

  regfile_hilo #(.FWD_EN(1'b0), .HILO_EN(1'b1)) dut_nofwd (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(n_rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(n_rdata2),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i), .hi_o(n_hi_o), .lo_o(n_lo_o)
  );

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] a, input bit fwd);
    if (!rst) return 32'd0;
    if (!en) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (fwd && we && a == waddr) return wdata;
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] m_hilo(input bit fwd, input bit is_hi);
    if (!rst) return 32'd0;
    if (fwd && whilo) return is_hi ? hi_i : lo_i;
    return is_hi ? m_hi : m_lo;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".fwd.rdata1"}, f_rdata1, m_read(re1, raddr1, 1'b1));
    chk({tag, ".fwd.rdata2"}, f_rdata2, m_read(re2, raddr2, 1'b1));
    chk({tag, ".fwd.hi_o"},   f_hi_o,   m_hilo(1'b1, 1'b1));
    chk({tag, ".fwd.lo_o"},   f_lo_o,   m_hilo(1'b1, 1'b0));
    chk({tag, ".nof.rdata1"}, n_rdata1, m_read(re1, raddr1, 1'b0));
    chk({tag, ".nof.rdata2"}, n_rdata2, m_read(re2, raddr2, 1'b0));
    chk({tag, ".nof.hi_o"},   n_hi_o,   m_hilo(1'b0, 1'b1));
    chk({tag, ".nof.lo_o"},   n_lo_o,   m_hilo(1'b0, 1'b0));
  endtask

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  // Advance one rising edge; the model commits whatever the inputs request at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (we && waddr != 5'd0) m_gpr[waddr] = wdata;
      if (whilo) begin
        m_hi = hi_i;
        m_lo = lo_i;
      end
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    whilo = 1'b0; hi_i = 32'd0; lo_i = 32'd0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    m_clear();
    #2;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd17;
    check_all("reset_state");
    #10;
    rst = 1'b1;
    idle();

    // Basic write then read
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd5;
    check_all("basic_rd");

    // r0 hardwire
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    check_all("r0_during");
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    check_all("r0_after");

    // Bypass versus latency-1 visibility
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'h22222222; re2 = 1'b1; raddr2 = 5'd7;
    re1 = 1'b1; raddr1 = 5'd7;
    check_all("bypass");
    tick();
    we = 1'b0;
    check_all("bypass_after");

    // HI/LO write, hold, and an unrequested update
    whilo = 1'b1; hi_i = 32'hA5A5A5A5; lo_i = 32'h5A5A5A5A;
    check_all("hilo_wr");
    tick();
    whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
    check_all("hilo_hold");
    hi_i = 32'h12345678; lo_i = 32'h87654321;
    tick();
    check_all("hilo_nowr");

    // Simultaneous GPR and HI/LO write
    we = 1'b1; waddr = 5'd12; wdata = 32'hCAFEF00D;
    whilo = 1'b1; hi_i = 32'h01010101; lo_i = 32'h02020202;
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd12;
    check_all("gpr_and_hilo");

    // Async reset with a loaded file
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = i[4:0]; wdata = i;
      tick();
    end
    idle();
    whilo = 1'b1; hi_i = 32'hFFFFFFFF; lo_i = 32'hFFFFFFFF;
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd1;
    check_all("loaded");
    #2;
    rst = 1'b0;
    m_clear();
    check_all("async_rst");
    we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
    tick();
    check_all("rst_write_drop");
    #2;
    rst = 1'b1;
    idle();
    for (int i = 0; i < 32; i += 2) begin
      re1 = 1'b1; raddr1 = i[4:0]; re2 = 1'b1; raddr2 = 5'(i + 1);
      check_all("post_rst_rd");
    end

    // Disabled read, including unknown address
    we = 1'b1; waddr = 5'd3; wdata = 32'h1234;
    tick();
    idle(); re1 = 1'b0; raddr1 = 5'd3;
    check_all("rd_disabled");
    raddr1 = 5'bxxxxx;
    check_all("rd_disabled_x");
    re1 = 1'b1; raddr1 = 5'd3;
    check_all("rd_enabled");

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
      re1 = ($urandom_range(0, 7) != 0); re2 = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      whilo = ($urandom_range(0, 3) == 0); hi_i = $urandom; lo_i = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        m_clear();
      end
      check_all("rand");
      tick();
      if (!rst) begin
        #2;
        rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
